// File: rtl/sbr_egr_crd_ccf.sv
// Sideband egress credit gate: per-channel NP/PC flit FIFOs, credit counters and a message dispatcher.
// Optional even-parity output mparity is enabled by defining SBR_EGR_PARITY_EN.
module sbr_egr_crd_ccf #(
    parameter int PAYLOAD_WIDTH = 8,
    parameter int FIFO_DEPTH    = 4,
    parameter int MAX_CRD       = 15
) (
    input  logic                     clk,
    input  logic                     rep_rst,
    input  logic                     in_valid,
    input  logic                     in_np,
    input  logic                     in_eom,
    input  logic [PAYLOAD_WIDTH-1:0] in_payload,
    output logic                     in_ready,
    input  logic [2:0]               side_ism_agent,
    output logic                     mnpput,
    output logic                     mpcput,
    output logic                     meom,
    output logic [PAYLOAD_WIDTH-1:0] mpayload,
`ifdef SBR_EGR_PARITY_EN
    output logic                     mparity,
`endif
    input  logic                     mnpcup,
    input  logic                     mpccup,
    output logic                     crd_err,
    output logic                     clk_req
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(MAX_CRD + 1);
    localparam int EW = PAYLOAD_WIDTH + 1;
    localparam logic [CW-1:0] CRD_MAX = CW'(MAX_CRD);

    typedef enum logic [1:0] {IDLE, SEND_PC, SEND_NP} state_t;

    logic [EW-1:0] mem_pc [FIFO_DEPTH];
    logic [EW-1:0] mem_np [FIFO_DEPTH];
    logic [AW:0]   wp_pc, rp_pc, wp_np, rp_np;
    logic [CW-1:0] crd_pc, crd_np;
    state_t        state;
    logic          last_np, msg_done;

    logic empty_pc, empty_np, full_pc, full_np;
    logic push_pc, push_np, pop_pc, pop_np;
    logic elig_pc, elig_np, start_pc, start_np, ism_active;
    logic [EW-1:0] head_pc, head_np;

    assign empty_pc = (wp_pc == rp_pc);
    assign empty_np = (wp_np == rp_np);
    assign full_pc  = (wp_pc[AW] != rp_pc[AW]) && (wp_pc[AW-1:0] == rp_pc[AW-1:0]);
    assign full_np  = (wp_np[AW] != rp_np[AW]) && (wp_np[AW-1:0] == rp_np[AW-1:0]);
    assign in_ready = in_np ? ~full_np : ~full_pc;
    assign push_pc  = in_valid & in_ready & ~in_np;
    assign push_np  = in_valid & in_ready & in_np;
    assign head_pc  = mem_pc[rp_pc[AW-1:0]];
    assign head_np  = mem_np[rp_np[AW-1:0]];

    assign ism_active = (side_ism_agent == 3'b011);
    assign elig_pc    = ism_active & ~empty_pc & (crd_pc != '0);
    assign elig_np    = ism_active & ~empty_np & (crd_np != '0);
    assign start_pc   = (state == IDLE) & elig_pc & (~elig_np | last_np);
    assign start_np   = (state == IDLE) & elig_np & (~elig_pc | ~last_np);
    assign pop_pc     = start_pc | ((state == SEND_PC) & ~msg_done & ~empty_pc);
    assign pop_np     = start_np | ((state == SEND_NP) & ~msg_done & ~empty_np);

    assign clk_req = ~empty_pc | ~empty_np | (state != IDLE) | mpcput | mnpput;

    always_ff @(posedge clk) begin
        if (push_pc) mem_pc[wp_pc[AW-1:0]] <= {in_eom, in_payload};
        if (push_np) mem_np[wp_np[AW-1:0]] <= {in_eom, in_payload};
    end

    always_ff @(posedge clk or posedge rep_rst) begin
        if (rep_rst) begin
            wp_pc <= '0;
            rp_pc <= '0;
            wp_np <= '0;
            rp_np <= '0;
        end else begin
            if (push_pc) wp_pc <= wp_pc + 1'b1;
            if (pop_pc)  rp_pc <= rp_pc + 1'b1;
            if (push_np) wp_np <= wp_np + 1'b1;
            if (pop_np)  rp_np <= rp_np + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rep_rst) begin
        if (rep_rst) begin
            crd_pc  <= '0;
            crd_np  <= '0;
            crd_err <= 1'b0;
        end else begin
            if (mpccup && !start_pc) begin
                if (crd_pc == CRD_MAX) crd_err <= 1'b1;
                else                   crd_pc  <= crd_pc + 1'b1;
            end else if (!mpccup && start_pc) begin
                crd_pc <= crd_pc - 1'b1;
            end
            if (mnpcup && !start_np) begin
                if (crd_np == CRD_MAX) crd_err <= 1'b1;
                else                   crd_np  <= crd_np + 1'b1;
            end else if (!mnpcup && start_np) begin
                crd_np <= crd_np - 1'b1;
            end
        end
    end

    // msg_done marks a single-flit message whose eom left on the start pop; the
    // SEND cycle then pops nothing. last_np only moves on contested grants.
    always_ff @(posedge clk or posedge rep_rst) begin
        if (rep_rst) begin
            state    <= IDLE;
            last_np  <= 1'b1;
            msg_done <= 1'b0;
            mpcput   <= 1'b0;
            mnpput   <= 1'b0;
            meom     <= 1'b0;
            mpayload <= '0;
`ifdef SBR_EGR_PARITY_EN
            mparity  <= 1'b0;
`endif
        end else begin
            mpcput <= pop_pc;
            mnpput <= pop_np;
            if (pop_pc) begin
                {meom, mpayload} <= head_pc;
`ifdef SBR_EGR_PARITY_EN
                mparity <= ^head_pc;
`endif
            end else if (pop_np) begin
                {meom, mpayload} <= head_np;
`ifdef SBR_EGR_PARITY_EN
                mparity <= ^head_np;
`endif
            end
            case (state)
                IDLE: begin
                    if (start_pc) begin
                        state    <= SEND_PC;
                        msg_done <= head_pc[PAYLOAD_WIDTH];
                        if (elig_np) last_np <= 1'b0;
                    end else if (start_np) begin
                        state    <= SEND_NP;
                        msg_done <= head_np[PAYLOAD_WIDTH];
                        if (elig_pc) last_np <= 1'b1;
                    end
                end
                SEND_PC: begin
                    if (msg_done || (pop_pc && head_pc[PAYLOAD_WIDTH])) begin
                        state    <= IDLE;
                        msg_done <= 1'b0;
                    end
                end
                SEND_NP: begin
                    if (msg_done || (pop_np && head_np[PAYLOAD_WIDTH])) begin
                        state    <= IDLE;
                        msg_done <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sbr_egr_crd_ccf.sv
// Directed-vector bench for sbr_egr_crd_ccf: credit init, credit gating, arbitration,
// bubble/full, credit overflow and reset mid-message.
module tb_sbr_egr_crd_ccf;
    localparam int PW = 8;

    logic          clk = 1'b0;
    logic          rep_rst = 1'b1;
    logic          in_valid = 1'b0, in_np = 1'b0, in_eom = 1'b0;
    logic [PW-1:0] in_payload = '0;
    logic [2:0]    side_ism_agent = 3'b011;
    logic          mnpcup = 1'b0, mpccup = 1'b0;
    logic          in_ready, mnpput, mpcput, meom, crd_err, clk_req;
    logic [PW-1:0] mpayload;
`ifdef SBR_EGR_PARITY_EN
    logic          mparity;
`endif

    sbr_egr_crd_ccf #(.PAYLOAD_WIDTH(PW), .FIFO_DEPTH(4), .MAX_CRD(15)) dut (
        .clk(clk), .rep_rst(rep_rst),
        .in_valid(in_valid), .in_np(in_np), .in_eom(in_eom), .in_payload(in_payload),
        .in_ready(in_ready), .side_ism_agent(side_ism_agent),
        .mnpput(mnpput), .mpcput(mpcput), .meom(meom), .mpayload(mpayload),
`ifdef SBR_EGR_PARITY_EN
        .mparity(mparity),
`endif
        .mnpcup(mnpcup), .mpccup(mpccup), .crd_err(crd_err), .clk_req(clk_req)
    );

    always #5 clk = ~clk;

    int unsigned pass_cnt = 0;
    int unsigned total_cnt = 0;

    typedef struct {
        logic          valid, np, eom;
        logic [PW-1:0] pl;
        logic          pccup, npcup;
        logic          x_ready, x_pc, x_np, x_eom;
        logic [PW-1:0] x_pl;
        logic          x_clk;
    } vec_t;

    vec_t vt [18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        in_valid = 1'b0; in_np = 1'b0; in_eom = 1'b0; in_payload = '0;
        mpccup = 1'b0; mnpcup = 1'b0;
    endtask

    task automatic push(input logic np, input logic eom, input logic [PW-1:0] pl);
        in_valid = 1'b1; in_np = np; in_eom = eom; in_payload = pl;
        tick();
        idle_in();
    endtask

    task automatic do_reset();
        idle_in();
        side_ism_agent = 3'b011;
        rep_rst = 1'b1;
        tick();
        tick();
        rep_rst = 1'b0;
    endtask

    task automatic chk_put(input string tag, input logic pc, input logic np);
        chk({tag, "_pcput"}, 32'(mpcput), 32'(pc));
        chk({tag, "_npput"}, 32'(mnpput), 32'(np));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int unsigned np_cnt;
        //          valid np eom pl     pcc npc  rdy pc np eom x_pl   clk
        vt[0]  = '{1'b0,1'b0,1'b0,8'h00,1'b1,1'b0, 1'b1,1'b0,1'b0,1'b0,8'h00,1'b0};
        vt[1]  = '{1'b0,1'b0,1'b0,8'h00,1'b1,1'b0, 1'b1,1'b0,1'b0,1'b0,8'h00,1'b0};
        vt[2]  = '{1'b1,1'b0,1'b0,8'hA1,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b0,8'h00,1'b1};
        vt[3]  = '{1'b1,1'b0,1'b0,8'hA2,1'b0,1'b0, 1'b1,1'b1,1'b0,1'b0,8'hA1,1'b1};
        vt[4]  = '{1'b1,1'b0,1'b1,8'hA3,1'b0,1'b0, 1'b1,1'b1,1'b0,1'b0,8'hA2,1'b1};
        vt[5]  = '{1'b0,1'b0,1'b0,8'h00,1'b0,1'b0, 1'b1,1'b1,1'b0,1'b1,8'hA3,1'b1};
        vt[6]  = '{1'b0,1'b0,1'b0,8'h00,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b1,8'hA3,1'b0};
        vt[7]  = '{1'b1,1'b0,1'b1,8'hB1,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b1,8'hA3,1'b1};
        vt[8]  = '{1'b0,1'b0,1'b0,8'h00,1'b0,1'b0, 1'b1,1'b1,1'b0,1'b1,8'hB1,1'b1};
        vt[9]  = '{1'b1,1'b0,1'b1,8'hC1,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b1,8'hB1,1'b1};
        vt[10] = '{1'b0,1'b0,1'b0,8'h00,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b1,8'hB1,1'b1};
        vt[11] = '{1'b0,1'b0,1'b0,8'h00,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b1,8'hB1,1'b1};
        vt[12] = '{1'b1,1'b1,1'b1,8'h51,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b1,8'hB1,1'b1};
        vt[13] = '{1'b0,1'b0,1'b0,8'h00,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b1,8'hB1,1'b1};
        vt[14] = '{1'b0,1'b0,1'b0,8'h00,1'b0,1'b1, 1'b1,1'b0,1'b0,1'b1,8'hB1,1'b1};
        vt[15] = '{1'b0,1'b0,1'b0,8'h00,1'b0,1'b0, 1'b1,1'b0,1'b1,1'b1,8'h51,1'b1};
        vt[16] = '{1'b0,1'b0,1'b0,8'h00,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b1,8'h51,1'b1};
        vt[17] = '{1'b0,1'b0,1'b0,8'h00,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b1,8'h51,1'b1};

        // Reset state
        do_reset();
        chk_put("rst", 1'b0, 1'b0);
        chk("rst_meom", 32'(meom), 0);
        chk("rst_mpayload", 32'(mpayload), 0);
        chk("rst_crd_err", 32'(crd_err), 0);
        chk("rst_clk_req", 32'(clk_req), 0);
        chk("rst_in_ready", 32'(in_ready), 1);

        // Credit init, 3-flit PC message, credit gating on PC and NP
        for (int i = 0; i < 18; i++) begin
            in_valid = vt[i].valid; in_np = vt[i].np; in_eom = vt[i].eom;
            in_payload = vt[i].pl; mpccup = vt[i].pccup; mnpcup = vt[i].npcup;
            #1;
            chk($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'(vt[i].x_ready));
            tick();
            chk_put($sformatf("v%0d", i), vt[i].x_pc, vt[i].x_np);
            chk($sformatf("v%0d_meom", i), 32'(meom), 32'(vt[i].x_eom));
            chk($sformatf("v%0d_mpayload", i), 32'(mpayload), 32'(vt[i].x_pl));
            chk($sformatf("v%0d_clk_req", i), 32'(clk_req), 32'(vt[i].x_clk));
`ifdef SBR_EGR_PARITY_EN
            chk($sformatf("v%0d_mparity", i), 32'(mparity), 32'(^{vt[i].x_eom, vt[i].x_pl}));
`endif
        end
        idle_in();

        // Arbitration: PC wins first tie, NP wins the repeat
        do_reset();
        for (int r = 0; r < 2; r++) begin
            side_ism_agent = 3'b000;
            mpccup = 1'b1; mnpcup = 1'b1;
            tick();
            idle_in();
            push(1'b0, 1'b1, 8'h60 + 8'(r));
            push(1'b1, 1'b1, 8'h70 + 8'(r));
            side_ism_agent = 3'b011;
            tick();
            chk_put($sformatf("arb%0d_first", r), r == 0, r == 1);
            chk($sformatf("arb%0d_first_pl", r), 32'(mpayload), r == 0 ? 32'h60 : 32'h71);
            tick();
            chk_put($sformatf("arb%0d_gap", r), 1'b0, 1'b0);
            tick();
            chk_put($sformatf("arb%0d_second", r), r == 1, r == 0);
            chk($sformatf("arb%0d_second_pl", r), 32'(mpayload), r == 0 ? 32'h70 : 32'h61);
            tick();
            chk_put($sformatf("arb%0d_after", r), 1'b0, 1'b0);
        end

        // Full FIFO, drain with bubble, no NP interleave
        do_reset();
        for (int i = 0; i < 4; i++) begin
            in_np = 1'b0;
            #1;
            chk($sformatf("fill%0d_ready", i), 32'(in_ready), 1);
            push(1'b0, 1'b0, 8'h10 + 8'(i));
        end
        in_valid = 1'b1; in_np = 1'b0; in_payload = 8'h99;
        #1;
        chk("full_pc_ready", 32'(in_ready), 0);
        tick();
        chk("full_pc_ready_held", 32'(in_ready), 0);
        in_valid = 1'b0; in_np = 1'b1;
        #1;
        chk("full_np_side_ready", 32'(in_ready), 1);
        in_valid = 1'b1; in_np = 1'b1; in_eom = 1'b1; in_payload = 8'h55;
        mpccup = 1'b1; mnpcup = 1'b1;
        tick();
        idle_in();
        chk_put("fill_nocrd", 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_put($sformatf("drain%0d", i), 1'b1, 1'b0);
            chk($sformatf("drain%0d_pl", i), 32'(mpayload), 32'h10 + 32'(i));
            chk($sformatf("drain%0d_eom", i), 32'(meom), 0);
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            chk_put($sformatf("bubble%0d", i), 1'b0, 1'b0);
            chk($sformatf("bubble%0d_clk_req", i), 32'(clk_req), 1);
        end
        push(1'b0, 1'b1, 8'h14);
        chk_put("eom_push", 1'b0, 1'b0);
        tick();
        chk_put("eom_sent", 1'b1, 1'b0);
        chk("eom_sent_eom", 32'(meom), 1);
        chk("eom_sent_pl", 32'(mpayload), 32'h14);
        np_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (mnpput) np_cnt++;
        end
        chk("np_after_pc_count", np_cnt, 1);
        chk("np_after_pc_pl", 32'(mpayload), 32'h55);

        // Credit overflow and sticky error
        do_reset();
        for (int i = 1; i <= 16; i++) begin
            mpccup = 1'b1;
            tick();
            if (i == 15) chk("ovf_15_crd_err", 32'(crd_err), 0);
        end
        idle_in();
        chk("ovf_16_crd_err", 32'(crd_err), 1);
        push(1'b0, 1'b1, 8'h3C);
        tick();
        chk_put("ovf_traffic", 1'b1, 1'b0);
        tick();
        chk("ovf_crd_err_held", 32'(crd_err), 1);
        rep_rst = 1'b1;
        #1;
        chk("ovf_crd_err_cleared", 32'(crd_err), 0);
        tick();
        rep_rst = 1'b0;

        // Reset mid-message discards the remaining flits
        do_reset();
        mpccup = 1'b1;
        tick();
        idle_in();
        side_ism_agent = 3'b000;
        push(1'b0, 1'b0, 8'h21);
        push(1'b0, 1'b0, 8'h22);
        push(1'b0, 1'b0, 8'h23);
        push(1'b0, 1'b1, 8'h24);
        side_ism_agent = 3'b011;
        tick();
        chk("mid_flit1_pl", 32'(mpayload), 32'h21);
        tick();
        chk_put("mid_flit2", 1'b1, 1'b0);
        chk("mid_flit2_pl", 32'(mpayload), 32'h22);
        rep_rst = 1'b1;
        #1;
        chk_put("mid_rst", 1'b0, 1'b0);
        chk("mid_rst_meom", 32'(meom), 0);
        chk("mid_rst_pl", 32'(mpayload), 0);
        chk("mid_rst_clk_req", 32'(clk_req), 0);
        tick();
        rep_rst = 1'b0;
        mpccup = 1'b1;
        tick();
        idle_in();
        push(1'b0, 1'b1, 8'h77);
        tick();
        chk_put("mid_new", 1'b1, 1'b0);
        chk("mid_new_pl", 32'(mpayload), 32'h77);
        chk("mid_new_eom", 32'(meom), 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_put($sformatf("mid_quiet%0d", i), 1'b0, 1'b0);
        end
        chk("mid_quiet_pl", 32'(mpayload), 32'h77);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
